multi_project_mux: RTL
======================

MULTI_PROJECT_MUX -- requirements
Module: multi_project_mux

Interface
REQ-001 Parameter N_PROJECTS, default 8, number of hosted projects (2..16).
REQ-002 Parameter GPIO_W, default 10, shared GPIO width (1..32).
REQ-003 Parameter GUARD_CYCLES, default 2, tristate guard length in cycles (>=1).
REQ-004 Parameter RESET_CYCLES, default 4, project reset hold length in cycles (>=1).
REQ-005 Localparam ID_W = max(1, clog2(N_PROJECTS+1)).
REQ-006 clk  input  1  single clock; all state on rising edge.
REQ-007 reset  input  1  synchronous, active-low block reset.
REQ-008 sel_valid  input  1  project-select request.
REQ-009 sel_id  input  ID_W  requested project index.
REQ-010 sel_ready  output  1  request accepted on cycle where sel_valid && sel_ready.
REQ-011 gpio_in  input  GPIO_W  pad inputs.
REQ-012 gpio_out  output  GPIO_W  pad outputs.
REQ-013 gpio_oeb  output  GPIO_W  pad output-enable, active-low (1 = hi-Z).
REQ-014 proj_gpio_out  input  N_PROJECTS*GPIO_W  project outputs; project k at bits [k*GPIO_W +: GPIO_W].
REQ-015 proj_gpio_oeb  input  N_PROJECTS*GPIO_W  project output-enables, same packing.
REQ-016 proj_gpio_in  output  N_PROJECTS*GPIO_W  per-project input copies, same packing.
REQ-017 proj_reset_n  output  N_PROJECTS  per-project active-low reset.
REQ-018 active_id  output  ID_W  index of project in RUN; 0 when none.
REQ-019 active_valid  output  1  high only in RUN.
REQ-020 sel_err  output  1  sticky: last accepted sel_id was >= N_PROJECTS.

Function
REQ-021 FSM states: IDLE, DRAIN, HOLD, RUN; one down-counter, width clog2(max(GUARD_CYCLES,RESET_CYCLES)+1).
REQ-022 sel_ready = 1 in IDLE and RUN, 0 in DRAIN and HOLD; requests while busy are ignored, not queued.
REQ-023 Accept at cycle T: target id registered; state DRAIN on T+1 for exactly GUARD_CYCLES cycles.
REQ-024 DRAIN: gpio_oeb all 1, gpio_out all 0; previously active project keeps its reset released (drains while tristated).
REQ-025 HOLD: follows DRAIN for exactly RESET_CYCLES cycles; proj_reset_n all 0; gpio_oeb all 1, gpio_out 0.
REQ-026 After HOLD: valid target -> RUN from cycle T+GUARD_CYCLES+RESET_CYCLES+1; invalid target -> IDLE at same cycle.
REQ-027 RUN: proj_reset_n[active_id]=1, all others 0; gpio_out/gpio_oeb = that project's slice, combinational pass-through.
REQ-028 IDLE: proj_reset_n all 0; gpio_oeb all 1; gpio_out 0; active_valid 0.
REQ-029 proj_gpio_in: active project's slice = gpio_in in RUN; every other slice, and all slices outside RUN, = 0.
REQ-030 Accepted sel_id equal to current active_id performs a full DRAIN/HOLD restart of that project.
REQ-031 Accepted sel_id >= N_PROJECTS sets sel_err and passes DRAIN/HOLD to IDLE; accepted valid id clears sel_err at T+1.
REQ-032 sel_id sampled only on the accept cycle; changes at other times have no effect.
REQ-033 proj_reset_n, active_id, active_valid, sel_err, FSM state are registered; no combinational path from sel_* to proj_reset_n.

Reset
REQ-034 reset low at a clk edge: next cycle state IDLE, counter 0, active_id 0, active_valid 0, sel_err 0, proj_reset_n all 0, gpio_oeb all 1, gpio_out 0, sel_ready 1.
REQ-035 reset low mid-DRAIN, mid-HOLD or in RUN aborts immediately to REQ-034 values; pending target discarded.
REQ-036 reset dominates a simultaneous sel_valid; the request is not accepted.

Verification
REQ-037 Defaults; reset, select id 3 at T -> DRAIN T+1..T+2, HOLD T+3..T+6, RUN T+7; proj_reset_n=8'b0000_1000; gpio_out=project 3 slice.
REQ-038 RUN id 3; select id 5 -> gpio_oeb=10'h3FF from next cycle, project 3 reset at HOLD entry, id 5 live 7 cycles after accept.
REQ-039 During HOLD drive sel_valid with id 1 every cycle -> sel_ready 0, request ignored, RUN with original target.
REQ-040 Select id 9 (N_PROJECTS=8) -> sel_err=1, IDLE after 6 cycles, all resets low; then select id 2 -> sel_err 0 at T+1.
REQ-041 RUN id 3; gpio_in=10'h155 -> slice 3 of proj_gpio_in=10'h155, all other slices 0.
REQ-042 reset low during HOLD -> next cycle all REQ-034 values; parameter sweep N_PROJECTS=2, GPIO_W=1, GUARD_CYCLES=1, RESET_CYCLES=1 -> RUN at T+3.

Source files
------------

// File: rtl/multi_project_mux.sv
// Time-shares one GPIO bank among several hosted projects. A select request drains the
// bank (tristated), holds every project in reset, then hands the pads to the chosen project.
module multi_project_mux #(
   parameter int unsigned N_PROJECTS   = 8,
   parameter int unsigned GPIO_W       = 10,
   parameter int unsigned GUARD_CYCLES = 2,
   parameter int unsigned RESET_CYCLES = 4,
   localparam int unsigned ID_W = ($clog2(N_PROJECTS + 1) > 1) ? $clog2(N_PROJECTS + 1) : 1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         sel_valid,
   input  logic [ID_W-1:0]              sel_id,
   output logic                         sel_ready,
   input  logic [GPIO_W-1:0]            gpio_in,
   output logic [GPIO_W-1:0]            gpio_out,
   output logic [GPIO_W-1:0]            gpio_oeb,
   input  logic [N_PROJECTS*GPIO_W-1:0] proj_gpio_out,
   input  logic [N_PROJECTS*GPIO_W-1:0] proj_gpio_oeb,
   output logic [N_PROJECTS*GPIO_W-1:0] proj_gpio_in,
   output logic [N_PROJECTS-1:0]        proj_reset_n,
   output logic [ID_W-1:0]              active_id,
   output logic                         active_valid,
   output logic                         sel_err
);

   localparam int unsigned MAX_CYC = (GUARD_CYCLES > RESET_CYCLES) ? GUARD_CYCLES : RESET_CYCLES;
   localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

   typedef enum logic [1:0] {StIdle, StDrain, StHold, StRun} state_e;

   state_e                  state_q;
   logic [CNT_W-1:0]        cnt_q;
   logic [ID_W-1:0]         target_q;
   logic [ID_W-1:0]         active_id_q;
   logic                    active_valid_q;
   logic                    sel_err_q;
   logic [N_PROJECTS-1:0]   proj_reset_n_q;
   logic                    target_ok;
   logic [N_PROJECTS-1:0]   target_onehot;

   assign target_ok = 32'(target_q) < N_PROJECTS;

   always_comb begin
      target_onehot = '0;
      for (int k = 0; k < int'(N_PROJECTS); k++) begin
         target_onehot[k] = (target_q == ID_W'(k));
      end
   end

   // Accept only from IDLE/RUN; the old project's reset stays released through DRAIN.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q        <= StIdle;
         cnt_q          <= '0;
         target_q       <= '0;
         active_id_q    <= '0;
         active_valid_q <= 1'b0;
         sel_err_q      <= 1'b0;
         proj_reset_n_q <= '0;
      end else begin
         unique case (state_q)
            StIdle, StRun: begin
               if (sel_valid) begin
                  state_q        <= StDrain;
                  cnt_q          <= CNT_W'(GUARD_CYCLES - 1);
                  target_q       <= sel_id;
                  sel_err_q      <= (32'(sel_id) >= N_PROJECTS);
                  active_id_q    <= '0;
                  active_valid_q <= 1'b0;
               end
            end
            StDrain: begin
               if (cnt_q == '0) begin
                  state_q        <= StHold;
                  cnt_q          <= CNT_W'(RESET_CYCLES - 1);
                  proj_reset_n_q <= '0;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            StHold: begin
               if (cnt_q == '0) begin
                  if (target_ok) begin
                     state_q        <= StRun;
                     active_id_q    <= target_q;
                     active_valid_q <= 1'b1;
                     proj_reset_n_q <= target_onehot;
                  end else begin
                     state_q <= StIdle;
                  end
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign sel_ready    = (state_q == StIdle) || (state_q == StRun);
   assign proj_reset_n = proj_reset_n_q;
   assign active_id    = active_id_q;
   assign active_valid = active_valid_q;
   assign sel_err      = sel_err_q;

   always_comb begin
      gpio_out     = '0;
      gpio_oeb     = '1;
      proj_gpio_in = '0;
      if (state_q == StRun) begin
         for (int k = 0; k < int'(N_PROJECTS); k++) begin
            if (active_id_q == ID_W'(k)) begin
               gpio_out                          = proj_gpio_out[k*GPIO_W +: GPIO_W];
               gpio_oeb                          = proj_gpio_oeb[k*GPIO_W +: GPIO_W];
               proj_gpio_in[k*GPIO_W +: GPIO_W]  = gpio_in;
            end
         end
      end
   end

endmodule
